// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs, branch and memory status in,
// per-stage load/clear controls and status out.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_dest;
  logic       branch_taken;
  logic       mem_busy;
  logic       pc_ld;
  logic       if_id_ld;
  logic       if_id_clr;
  logic       id_ex_ld;
  logic       id_ex_clr;
  logic       ex_mem_ld;
  logic       mem_wb_ld;
  logic       stall;
  logic       mem_timeout;
  logic [1:0] hz_state;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_dest, branch_taken, mem_busy,
    input  pc_ld, if_id_ld, if_id_clr, id_ex_ld, id_ex_clr, ex_mem_ld, mem_wb_ld, stall,
           mem_timeout, hz_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_dest, branch_taken, mem_busy,
    output pc_ld, if_id_ld, if_id_clr, id_ex_ld, id_ex_clr, ex_mem_ld, mem_wb_ld, stall,
           mem_timeout, hz_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory freeze,
// branch flush and memory watchdog. Define HAZARD_PERF_CNT_EN for performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned FLUSH_ON_BRANCH  = 0,
  parameter int unsigned TIMEOUT          = 256,
  parameter int unsigned TO_W             = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_flushes
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t          state_q, state_d, ret_q, ret_d, eff;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [TO_W-1:0] wd_q;
  logic            to_q;
  logic            hz;
  logic            pc_ld, if_id_ld, if_id_clr, id_ex_ld, id_ex_clr, ex_mem_ld, mem_wb_ld, stall;

  assign hz = bus.ex_mem_read && (bus.ex_dest != 5'd0) &&
              ((bus.id_uses_rs && (bus.id_rs == bus.ex_dest)) ||
               (bus.id_uses_rt && (bus.id_rt == bus.ex_dest)));

  // FREEZE is transparent once memory is ready: behave as the state it interrupted.
  always_comb begin
    case (state_q)
      RUN, BUBBLE: eff = state_q;
      FREEZE:      eff = ret_q;
      default:     eff = RUN;
    endcase
  end

  always_comb begin
    pc_ld     = 1'b1;
    if_id_ld  = 1'b1;
    if_id_clr = 1'b0;
    id_ex_ld  = 1'b1;
    id_ex_clr = 1'b0;
    ex_mem_ld = 1'b1;
    mem_wb_ld = 1'b1;
    stall     = 1'b0;
    state_d   = RUN;
    ret_d     = ret_q;
    bcnt_d    = bcnt_q;
    if (reset) begin
      pc_ld     = 1'b0;
      if_id_ld  = 1'b0;
      id_ex_ld  = 1'b0;
      ex_mem_ld = 1'b0;
      mem_wb_ld = 1'b0;
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end else if (bus.mem_busy) begin
      pc_ld     = 1'b0;
      if_id_ld  = 1'b0;
      id_ex_ld  = 1'b0;
      ex_mem_ld = 1'b0;
      mem_wb_ld = 1'b0;
      stall     = 1'b1;
      ret_d     = eff;
      state_d   = FREEZE;
    end else if (eff == BUBBLE || hz) begin
      pc_ld     = 1'b0;
      if_id_ld  = 1'b0;
      id_ex_clr = 1'b1;
      stall     = 1'b1;
      if (eff == BUBBLE) begin
        bcnt_d  = bcnt_q - 2'd1;
        state_d = (bcnt_q == 2'd1) ? RUN : BUBBLE;
      end else if (LOAD_USE_BUBBLES > 1) begin
        bcnt_d  = 2'(LOAD_USE_BUBBLES - 1);
        state_d = BUBBLE;
      end
    end else if (bus.branch_taken && (FLUSH_ON_BRANCH != 0)) begin
      if_id_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      bcnt_q  <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bcnt_q  <= bcnt_d;
      if (bus.mem_busy) begin
        if (wd_q != '1) wd_q <= wd_q + TO_W'(1);
        if (wd_q == TO_W'(TIMEOUT - 1)) to_q <= 1'b1;
      end else begin
        wd_q <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_flushes      <= '0;
    end else begin
      if (stall)     perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (id_ex_clr) perf_bubbles      <= perf_bubbles + 32'd1;
      if (if_id_clr) perf_flushes      <= perf_flushes + 32'd1;
    end
  end
`endif

  assign bus.pc_ld       = pc_ld;
  assign bus.if_id_ld    = if_id_ld;
  assign bus.if_id_clr   = if_id_clr;
  assign bus.id_ex_ld    = id_ex_ld;
  assign bus.id_ex_clr   = id_ex_clr;
  assign bus.ex_mem_ld   = ex_mem_ld;
  assign bus.mem_wb_ld   = mem_wb_ld;
  assign bus.stall       = stall;
  assign bus.mem_timeout = to_q;
  assign bus.hz_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three configurations share one stimulus stream and
// are checked every cycle against a counting model of the stall/bubble/freeze rules.
module tb_pipeline_hazard_ctrl;
  localparam int N = 3;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [4:0] dest;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic       br;
    logic       busy;
  } stim_t;

  logic        clk = 1'b0;
  stim_t       cur;
  logic [10:0] got [N];
  int          checks = 0;
  int          failures = 0;

  // dut0: defaults; dut1: two bubbles, flush, short watchdog; dut2: one bubble, flush
  int unsigned lub  [N] = '{1, 2, 1};
  bit          flush[N] = '{1'b0, 1'b1, 1'b1};
  int unsigned tmo  [N] = '{256, 8, 5};
  int unsigned pend [N];
  int unsigned run  [N];
  bit          frz  [N];
  bit          tout [N];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ps [N], pb [N], pf [N];
  int unsigned m_stall [N], m_bub [N], m_fl [N];
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if ifs [N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign ifs[g].id_rs        = cur.rs;
    assign ifs[g].id_rt        = cur.rt;
    assign ifs[g].id_uses_rs   = cur.urs;
    assign ifs[g].id_uses_rt   = cur.urt;
    assign ifs[g].ex_mem_read  = cur.mr;
    assign ifs[g].ex_dest      = cur.dest;
    assign ifs[g].branch_taken = cur.br;
    assign ifs[g].mem_busy     = cur.busy;
    assign got[g] = {ifs[g].pc_ld, ifs[g].if_id_ld, ifs[g].if_id_clr, ifs[g].id_ex_ld,
                     ifs[g].id_ex_clr, ifs[g].ex_mem_ld, ifs[g].mem_wb_ld, ifs[g].stall,
                     ifs[g].mem_timeout, ifs[g].hz_state};
    pipeline_hazard_ctrl #(
      .LOAD_USE_BUBBLES(g == 1 ? 2 : 1),
      .FLUSH_ON_BRANCH (g == 0 ? 0 : 1),
      .TIMEOUT         (g == 0 ? 256 : (g == 1 ? 8 : 5)),
      .TO_W            (g == 0 ? 9 : (g == 1 ? 4 : 3))
    ) dut (
      .clk  (clk),
      .reset(cur.rst),
      .bus  (ifs[g])
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cycles(ps[g]),
      .perf_bubbles     (pb[g]),
      .perf_flushes     (pf[g])
`endif
    );
  end

  // Expected {pc,ifl,ifc,idl,idc,exl,wbl,stall,timeout,state} from the rules.
  function automatic logic [10:0] model_out(int d);
    logic [6:0] c;
    logic       s;
    bit         hz;
    hz = cur.mr && (cur.dest != 5'd0) &&
         ((cur.urs && cur.rs == cur.dest) || (cur.urt && cur.rt == cur.dest));
    s = 1'b0;
    if (cur.rst) c = 7'b0010100;
    else if (cur.busy) begin c = 7'b0000000; s = 1'b1; end
    else if (pend[d] > 0 || hz) begin c = 7'b0001111; s = 1'b1; end
    else if (cur.br && flush[d]) c = 7'b1111011;
    else c = 7'b1101011;
    return {c, s, tout[d], frz[d] ? 2'd2 : (pend[d] > 0 ? 2'd1 : 2'd0)};
  endfunction

  task automatic model_step();
    logic [10:0] o;
    for (int d = 0; d < N; d++) begin
      o = model_out(d);
      if (cur.rst) begin
        pend[d] = 0; run[d] = 0; frz[d] = 0; tout[d] = 0;
`ifdef HAZARD_PERF_CNT_EN
        m_stall[d] = 0; m_bub[d] = 0; m_fl[d] = 0;
`endif
      end else begin
`ifdef HAZARD_PERF_CNT_EN
        m_stall[d] += 32'(o[3]); m_bub[d] += 32'(o[6]); m_fl[d] += 32'(o[8]);
`endif
        if (cur.busy) begin
          frz[d] = 1; run[d]++;
          if (run[d] >= tmo[d]) tout[d] = 1;
        end else begin
          frz[d] = 0; run[d] = 0;
          if (o[6]) pend[d] = (pend[d] > 0) ? pend[d] - 1 : lub[d] - 1;
        end
      end
    end
  endtask

  task automatic drive(input stim_t s);
    cur = s;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic stim_t mk(logic mr, logic [4:0] dest, logic [4:0] rs, logic urs,
                               logic [4:0] rt, logic urt, logic br, logic busy);
    stim_t s;
    s.rst = 1'b0; s.mr = mr; s.dest = dest; s.rs = rs; s.urs = urs;
    s.rt = rt; s.urt = urt; s.br = br; s.busy = busy;
    return s;
  endfunction

  function automatic stim_t rst_stim();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic do_reset();
    drive(rst_stim());
    advance();
  endtask

  task automatic test_reset();
    stim_t s;
    for (int i = 0; i < 3; i++) begin
      s = mk(1'($urandom_range(1)), 5'($urandom_range(3)), 5'($urandom_range(3)), 1'b1,
             5'($urandom_range(3)), 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
      s.rst = 1'b1;
      drive(s);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          failures++;
          $display("FAIL reset[%0d] dut%0d got=%b exp=%b", i, d, got[d], model_out(d));
        end
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    do_reset();
    q = '{mk(1, 8, 8, 1, 0, 0, 0, 0), mk(0, 8, 8, 1, 0, 0, 0, 0), mk(0, 8, 8, 1, 0, 0, 0, 0)};
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          failures++;
          $display("FAIL load_use[%0d] dut%0d got=%b exp=%b", i, d, got[d], model_out(d));
        end
      end
      advance();
    end
  endtask

  task automatic test_zero_reg();
    stim_t q[$];
    do_reset();
    q = '{mk(1, 0, 0, 1, 0, 0, 0, 0), mk(1, 9, 3, 1, 9, 0, 0, 0),
          mk(1, 9, 3, 1, 9, 1, 0, 0), mk(0, 9, 3, 1, 9, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          failures++;
          $display("FAIL zero_reg[%0d] dut%0d got=%b exp=%b", i, d, got[d], model_out(d));
        end
      end
      advance();
    end
  endtask

  task automatic test_two_bubbles();
    stim_t q[$];
    int nb [N];
    do_reset();
    q = '{mk(1, 5, 0, 0, 5, 1, 0, 0), mk(0, 5, 0, 0, 5, 1, 0, 0),
          mk(0, 5, 0, 0, 5, 1, 0, 0), mk(0, 5, 0, 0, 5, 1, 0, 0)};
    foreach (nb[d]) nb[d] = 0;
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        nb[d] += int'(got[d][6]);
        checks++;
        if (got[d] !== model_out(d)) begin
          failures++;
          $display("FAIL two_bubbles[%0d] dut%0d got=%b exp=%b", i, d, got[d], model_out(d));
        end
      end
      advance();
    end
    checks++;
    if (nb[1] !== 2 || nb[0] !== 1) begin
      failures++;
      $display("FAIL bubble_count got=%0d/%0d exp=2/1", nb[1], nb[0]);
    end
  endtask

  task automatic test_freeze_bubble();
    stim_t q[$];
    do_reset();
    q = '{mk(1, 8, 8, 1, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 0, 0, 1),
          mk(0, 0, 0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          failures++;
          $display("FAIL freeze_bubble[%0d] dut%0d got=%b exp=%b", i, d, got[d], model_out(d));
        end
      end
      advance();
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (pb[1] !== 32'd2 || pb[0] !== 32'd1) begin
      failures++;
      $display("FAIL perf_bubbles got=%0d/%0d exp=2/1", pb[1], pb[0]);
    end
`endif
  endtask

  task automatic test_branch_flush();
    stim_t q[$];
    do_reset();
    q = '{mk(1, 8, 8, 1, 0, 0, 1, 0), mk(0, 0, 0, 0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0, 0, 1, 0),
          mk(0, 0, 0, 0, 0, 0, 1, 1), mk(0, 0, 0, 0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0, 0, 0, 0)};
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          failures++;
          $display("FAIL branch_flush[%0d] dut%0d got=%b exp=%b", i, d, got[d], model_out(d));
        end
      end
      advance();
    end
  endtask

  task automatic test_watchdog();
    stim_t q[$];
    do_reset();
    for (int i = 0; i < 10; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(rst_stim());
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          failures++;
          $display("FAIL watchdog[%0d] dut%0d got=%b exp=%b", i, d, got[d], model_out(d));
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    stim_t s;
    int    burst = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s = mk(1'($urandom_range(1)), 5'($urandom_range(3)), 5'($urandom_range(3)),
             1'($urandom_range(1)), 5'($urandom_range(3)), 1'($urandom_range(1)),
             1'($urandom_range(1)), 1'b0);
      if (burst > 0) begin
        s.busy = 1'b1;
        burst--;
      end else if ($urandom_range(7) == 0) begin
        burst = int'($urandom_range(9));
      end
      s.rst = ($urandom_range(59) == 0);
      drive(s);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          failures++;
          $display("FAIL random[%0d] dut%0d got=%b exp=%b", i, d, got[d], model_out(d));
        end
      end
      advance();
    end
`ifdef HAZARD_PERF_CNT_EN
    for (int d = 0; d < N; d++) begin
      checks++;
      if (ps[d] !== m_stall[d] || pb[d] !== m_bub[d] || pf[d] !== m_fl[d]) begin
        failures++;
        $display("FAIL perf dut%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", d, ps[d], pb[d], pf[d],
                 m_stall[d], m_bub[d], m_fl[d]);
      end
    end
`endif
  endtask

  initial begin
    do_reset();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_two_bubbles();
    test_freeze_bubble();
    test_branch_flush();
    test_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
